// File: rtl/mau_pkg.sv
// mau_pkg: shared op/exception encodings, FSM states and helpers for mem_access_unit
package mau_pkg;
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;
  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE = 2'b10;
  localparam logic [31:0] DM_LIMIT_DEFAULT = 32'h0000_3000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic is_store(input logic [2:0] op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    return ((op inside {OP_LW, OP_SW}) && off != 2'b00) || ((op inside {OP_LH, OP_LHU, OP_SH}) && off[0]);
  endfunction
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: store byte-enable/lane replication and load extract/extend
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    st_be   = st_op == OP_SH ? (st_off[1] ? 4'b1100 : 4'b0011) :
              st_op == OP_SB ? 4'b0001 << st_off : 4'b1111;
    st_data = st_op == OP_SH ? {2{st_wdata[15:0]}} :
              st_op == OP_SB ? {4{st_wdata[7:0]}} : st_wdata;
    b       = ld_rdata[{ld_off, 3'b000} +: 8];
    h       = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_op == OP_LB  ? {{24{b[7]}}, b} :
              ld_op == OP_LBU ? {24'd0, b} :
              ld_op == OP_LH  ? {{16{h[15]}}, h} :
              ld_op == OP_LHU ? {16'd0, h} : ld_rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for the data-memory port
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [1:0]  exc_chk;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  mau_lane_align u_align (
    .st_op    (req_op),
    .st_off   (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_op    (op_q),
    .ld_off   (off_q),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign mem_req    = state == ISSUE;
  assign resp_valid = state == RESP;
  assign exc_chk    = misaligned(req_op, req_addr[1:0]) ? EXC_ALIGN :
                      req_addr >= DM_LIMIT ? EXC_RANGE : EXC_NONE;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !req_valid ? IDLE : exc_chk != EXC_NONE ? RESP : ISSUE;
      ISSUE:   state_n = !mem_gnt ? ISSUE : mem_we ? RESP : WAIT;
      WAIT:    state_n = mem_rvalid ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end

  // response fields only change on entry to RESP so they hold between responses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      op_q       <= '0;
      off_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_exc   <= EXC_NONE;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid && exc_chk != EXC_NONE) begin
        resp_exc   <= exc_chk;
        resp_rdata <= '0;
      end
      if (state == IDLE && req_valid && exc_chk == EXC_NONE) begin
        op_q      <= req_op;
        off_q     <= req_addr[1:0];
        mem_we    <= is_store(req_op);
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_be    <= st_be;
        mem_wdata <= st_data;
      end
      if (state == ISSUE && mem_gnt && mem_we) begin
        resp_exc   <= EXC_NONE;
        resp_rdata <= '0;
      end
      if (state == WAIT && mem_rvalid) begin
        resp_exc   <= EXC_NONE;
        resp_rdata <= ld_data;
      end
    end
  end
endmodule
